// File: rtl/seq_divider_nr.sv
// Sequential non-restoring unsigned divider (DW-bit dividend, VW-bit divisor) with valid/ready ports.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor goes straight to DONE on the accepting edge.
`timescale 1ns/1ps
module seq_divider_nr #(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_zero,
  output logic [1:0]    state_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  // Handshake: a request transfers on an edge with in_valid && in_ready,
  // a result transfers on an edge with out_valid && out_ready.
  logic [1:0]    state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [VW:0]   part_q, part_d;
  logic [DW-1:0] shift_q, shift_d;
  logic [VW-1:0] div_q, div_d;
  logic          zero_q, zero_d;
  logic [DW-1:0] quot_q, quot_d;
  logic [VW-1:0] rem_q, rem_d;
  logic          dz_q, dz_d;

  logic [VW:0]   dvs_ext;
  logic [VW:0]   part_sh;
  logic [VW:0]   part_step;
  logic [VW-1:0] fix_sum;

  // The shifted partial may wrap in VW+1 bits; the post-add/sub value always fits.
  assign dvs_ext   = {1'b0, div_q};
  assign part_sh   = {part_q[VW-1:0], shift_q[DW-1]};
  assign part_step = part_q[VW] ? (part_sh + dvs_ext) : (part_sh - dvs_ext);
  assign fix_sum   = part_q[VW-1:0] + (part_q[VW] ? div_q : '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    part_d  = part_q;
    shift_d = shift_q;
    div_d   = div_q;
    zero_d  = zero_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shift_d = dividend;
          div_d   = divisor;
          part_d  = '0;
          cnt_d   = '0;
          zero_d  = (divisor == '0);
          state_d = RUN;
`ifdef DIV_ZERO_FAST_EN
          if (divisor == '0) begin
            quot_d  = '1;
            rem_d   = dividend[VW-1:0];
            dz_d    = 1'b1;
            state_d = DONE;
          end
`endif
        end
      end
      RUN: begin
        part_d  = part_step;
        shift_d = {shift_q[DW-2:0], ~part_step[VW]};
        cnt_d   = cnt_q + DW'(1);
        if (cnt_q == DW'(DW - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        // With a zero divisor the partial ends up holding the dividend's low bits.
        part_d  = {1'b0, fix_sum};
        quot_d  = zero_q ? '1 : shift_q;
        rem_d   = fix_sum;
        dz_d    = zero_q;
        state_d = DONE;
      end
      default: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      part_q  <= '0;
      shift_q <= '0;
      div_q   <= '0;
      zero_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      part_q  <= part_d;
      shift_q <= shift_d;
      div_q   <= div_d;
      zero_q  <= zero_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign div_zero  = dz_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_seq_divider_nr.sv
// Directed bench for seq_divider_nr: vector table at DW=8/VW=4, hold and reset-abort
// sequences, and an exhaustive sweep on a DW=4/VW=2 instance.
`timescale 1ns/1ps
module tb_seq_divider_nr;
  localparam int DW = 8;
  localparam int VW = 4;
  localparam int EW = DW + VW + 1;
`ifdef DIV_ZERO_FAST_EN
  localparam int ZLAT = 0;
`else
  localparam int ZLAT = DW + 1;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic          in_valid, in_ready, out_valid, out_ready, div_zero;
  logic [DW-1:0] dividend, quotient;
  logic [VW-1:0] divisor, remainder;
  logic [1:0]    state;

  logic       s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_div_zero;
  logic [3:0] s_dividend, s_quotient;
  logic [1:0] s_divisor, s_remainder, s_state;

  seq_divider_nr #(.DW(DW), .VW(VW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
    .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
    .div_zero(div_zero), .state_o(state)
  );

  seq_divider_nr #(.DW(4), .VW(2)) dut_s (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .dividend(s_dividend), .divisor(s_divisor), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .quotient(s_quotient), .remainder(s_remainder),
    .div_zero(s_div_zero), .state_o(s_state)
  );

  // scoreboard
  int n_cmp = 0;
  int n_bad = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [DW-1:0] a;
    logic [VW-1:0] b;
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic          dz;
    int            hold;
  } vec_t;

  vec_t vecs[13];

  // driver: called at a negedge with the DUT idle
  task automatic run_op(input logic [DW-1:0] a, input logic [VW-1:0] b,
                        input logic [EW-1:0] exp, input int exp_lat, input int hold);
    int n;
    logic busy_ok;
    logic [EW-1:0] e;
    exp_q.push_back(exp);
    check("in_ready_before", in_ready, 1);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk);
    n = 0;
    busy_ok = 1'b1;
    while (1) begin
      @(negedge clk);
      if (out_valid || n >= 40) break;
      if (in_ready) busy_ok = 1'b0;
      dividend = DW'($urandom);
      divisor  = VW'($urandom);
      @(posedge clk);
      n++;
    end
    in_valid = 1'b0;
    check("latency", n, exp_lat);
    check("in_ready_busy", busy_ok, 1);
    e = exp_q.pop_front();
    check("out_valid", out_valid, 1);
    check("quotient", quotient, e[DW+VW-1:VW]);
    check("remainder", remainder, e[VW-1:0]);
    check("div_zero", div_zero, e[EW-1]);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_result", {div_zero, quotient, remainder}, e);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("idle_after_ack", {in_ready, out_valid}, 2'b10);
  endtask

  task automatic run_small(input logic [3:0] a, input logic [1:0] b);
    int n;
    s_dividend = a;
    s_divisor  = b;
    s_in_valid = 1'b1;
    @(posedge clk);
    n = 0;
    while (1) begin
      @(negedge clk);
      s_in_valid = 1'b0;
      if (s_out_valid || n >= 20) break;
      @(posedge clk);
      n++;
    end
    check("s_latency", n, 5);
    check("s_quotient", s_quotient, a / b);
    check("s_remainder", s_remainder, a % b);
    s_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_out_ready = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic abort_ok;
    vecs[0]  = '{8'd200, 4'd7,  8'd28,  4'd4,  1'b0, 0};
    vecs[1]  = '{8'd255, 4'd1,  8'd255, 4'd0,  1'b0, 0};
    vecs[2]  = '{8'd5,   4'd9,  8'd0,   4'd5,  1'b0, 0};
    vecs[3]  = '{8'd100, 4'd0,  8'd255, 4'd4,  1'b1, 0};
    vecs[4]  = '{8'd77,  4'd6,  8'd12,  4'd5,  1'b0, 5};
    vecs[5]  = '{8'd0,   4'd5,  8'd0,   4'd0,  1'b0, 0};
    vecs[6]  = '{8'd15,  4'd15, 8'd1,   4'd0,  1'b0, 0};
    vecs[7]  = '{8'd255, 4'd15, 8'd17,  4'd0,  1'b0, 0};
    vecs[8]  = '{8'd254, 4'd15, 8'd16,  4'd14, 1'b0, 0};
    vecs[9]  = '{8'd7,   4'd0,  8'd255, 4'd7,  1'b1, 0};
    vecs[10] = '{8'd0,   4'd0,  8'd255, 4'd0,  1'b1, 0};
    vecs[11] = '{8'd128, 4'd3,  8'd42,  4'd2,  1'b0, 0};
    vecs[12] = '{8'd3,   4'd15, 8'd0,   4'd3,  1'b0, 2};

    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
    s_in_valid = 1'b0; s_out_ready = 1'b0; s_dividend = '0; s_divisor = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_quotient", quotient, 0);
    check("reset_remainder", remainder, 0);
    check("reset_div_zero", div_zero, 0);

    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].a, vecs[i].b, {vecs[i].dz, vecs[i].q, vecs[i].r},
             (vecs[i].b == 0) ? ZLAT : DW + 1, vecs[i].hold);
    end

    // reset four edges into 200/7: outputs clear immediately, no result appears
    dividend = 8'd200;
    divisor  = 4'd7;
    in_valid = 1'b1;
    @(posedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_quotient", quotient, 0);
    check("abort_remainder", remainder, 0);
    check("abort_div_zero", div_zero, 0);
    check("abort_out_valid", out_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    run_op(8'd13, 4'd3, {1'b0, 8'd4, 4'd1}, DW + 1, 0);
    abort_ok = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) abort_ok = 1'b0;
    end
    check("no_stray_result", abort_ok, 1);

    for (int a = 0; a < 16; a++) begin
      for (int b = 1; b < 4; b++) begin
        run_small(4'(a), 2'(b));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
